// File: rtl/cpu_io_bridge_pkg.sv
// Shared constants and types for the CPU memory-bus bridge.
// IO addresses are 18-bit values matching the decoded slice of the CPU address.
package cpu_io_bridge_pkg;

    localparam int BYTE_W = 8;

    localparam logic [17:0] IO_BASE = 18'h30000;
    localparam logic [17:0] IO_UART = 18'h00000;
    localparam logic [17:0] IO_CLK  = 18'h00004;

    localparam logic [17:0] ADDR_UART = IO_BASE | IO_UART;
    localparam logic [17:0] ADDR_CLK  = IO_BASE | IO_CLK;

    typedef enum logic {
        SEL_RAM = 1'b0,
        SEL_IO  = 1'b1
    } sel_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered read/write pointers; DEPTH must be a power of two.
// Latency: a pushed byte appears on pop_dat the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; the caller gates both.
module byte_fifo
    import cpu_io_bridge_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_dat,
    input  logic              pop,
    output logic [BYTE_W-1:0] pop_dat,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// CPU memory-bus bridge: routes byte accesses to unified RAM or UART/counter/halt IO.
// Latency: read data one cycle after an accepted read, held until the next accepted read.
// Backpressure: cpu_rdy drops on ext_rdy low, after halt, or for a TX push into a full FIFO.
module cpu_io_bridge
    import cpu_io_bridge_pkg::*;
#(
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter int RAM_ADDR_W = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  ext_rdy,
    input  logic [31:0]           cpu_a,
    input  logic [BYTE_W-1:0]     cpu_dout,
    input  logic                  cpu_wr,
    output logic [BYTE_W-1:0]     cpu_din,
    output logic                  cpu_rdy,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic [BYTE_W-1:0]     ram_wdata,
    output logic                  ram_we,
    input  logic [BYTE_W-1:0]     ram_rdata,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [BYTE_W-1:0]     rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  halted,
    output logic                  sim_done
);

    logic              is_io;
    logic              is_uart;
    logic              is_clk;
    logic              tx_wr_req;
    logic              acc;
    logic              rd_acc;
    logic              tx_push;
    logic [BYTE_W-1:0] tx_push_dat;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_push;
    logic              rx_pop;
    logic [BYTE_W-1:0] rx_head;
    logic              rx_full;
    logic              rx_empty;
    logic [BYTE_W-1:0] io_rd_dat;

    logic              rd_pend;
    sel_t              rd_sel;
    logic [BYTE_W-1:0] io_rd_q;
    logic [BYTE_W-1:0] din_hold;
    logic [31:0]       counter;
    logic [31:0]       snap;
    logic              unused_hi;

    assign unused_hi = ^cpu_a[31:18];

    assign is_io   = (cpu_a[17:16] == 2'b11);
    assign is_uart = (cpu_a[17:0] == ADDR_UART);
    assign is_clk  = (cpu_a[17:0] == ADDR_CLK);

    // A zero byte to the UART address is a no-op, so it never waits on a full FIFO.
    assign tx_wr_req = cpu_wr && ((is_uart && (cpu_dout != '0)) || is_clk);
    assign cpu_rdy   = ext_rdy && !halted && !(tx_wr_req && tx_full);
    assign acc       = cpu_rdy;
    assign rd_acc    = acc && !cpu_wr;

    assign ram_a     = cpu_a[RAM_ADDR_W-1:0];
    assign ram_wdata = cpu_dout;
    // Gated by reset so no stray RAM write escapes while the bridge is held in reset.
    assign ram_we    = rst_in && acc && !is_io && cpu_wr;

    assign tx_push     = acc && tx_wr_req;
    assign tx_push_dat = is_uart ? cpu_dout : '0;
    assign tx_valid    = !tx_empty;
    assign tx_pop      = tx_valid && tx_ready;

    assign rx_ready = rst_in && !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = rd_acc && is_uart && !rx_empty;

    always_comb begin
        io_rd_dat = '0;
        case (cpu_a[17:0])
            ADDR_UART:          io_rd_dat = rx_empty ? '0 : rx_head;
            ADDR_CLK:           io_rd_dat = counter[7:0];
            ADDR_CLK + 18'd1:   io_rd_dat = snap[15:8];
            ADDR_CLK + 18'd2:   io_rd_dat = snap[23:16];
            ADDR_CLK + 18'd3:   io_rd_dat = snap[31:24];
            default:            io_rd_dat = '0;
        endcase
    end

    assign cpu_din = rd_pend ? ((rd_sel == SEL_IO) ? io_rd_q : ram_rdata) : din_hold;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_pend  <= 1'b0;
            rd_sel   <= SEL_RAM;
            io_rd_q  <= '0;
            din_hold <= '0;
            counter  <= '0;
            snap     <= '0;
            halted   <= 1'b0;
            sim_done <= 1'b0;
        end else begin
            rd_pend  <= rd_acc;
            din_hold <= cpu_din;
            if (rd_acc) begin
                rd_sel  <= is_io ? SEL_IO : SEL_RAM;
                io_rd_q <= io_rd_dat;
            end
            // Low byte read freezes the whole word so the upper bytes stay coherent.
            if (rd_acc && is_clk) snap <= counter;
            if (ext_rdy && !halted) counter <= counter + 32'd1;
            if (acc && cpu_wr && is_clk) halted <= 1'b1;
            sim_done <= halted && tx_empty;
        end
    end

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (tx_push),
        .push_dat (tx_push_dat),
        .pop      (tx_pop),
        .pop_dat  (tx_data),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (rx_push),
        .push_dat (rx_data),
        .pop      (rx_pop),
        .pop_dat  (rx_head),
        .full     (rx_full),
        .empty    (rx_empty)
    );

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed bench for cpu_io_bridge: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_cpu_io_bridge;

    localparam int TXD = 16;
    localparam int RXD = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        ext_rdy;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic [16:0] ram_a;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halted;
    logic        sim_done;

    always #5 clk_in = ~clk_in;

    cpu_io_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .RAM_ADDR_W(17)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .ext_rdy   (ext_rdy),
        .cpu_a     (cpu_a),
        .cpu_dout  (cpu_dout),
        .cpu_wr    (cpu_wr),
        .cpu_din   (cpu_din),
        .cpu_rdy   (cpu_rdy),
        .ram_a     (ram_a),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .halted    (halted),
        .sim_done  (sim_done)
    );

    // External synchronous RAM, one-cycle read latency.
    logic [7:0] ram [0:131071];
    always @(posedge clk_in) begin
        if (ram_we) ram[ram_a] <= ram_wdata;
        ram_rdata <= ram[ram_a];
    end

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_txq[$];
    logic [7:0]  m_rxq[$];
    logic [7:0]  m_mem [int];
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic        m_halted;
    logic        m_done;
    logic [7:0]  m_din;

    function automatic logic m_io();
        return cpu_a[17:16] == 2'b11;
    endfunction

    function automatic logic [15:0] m_off();
        return cpu_a[15:0];
    endfunction

    function automatic logic m_txw();
        return m_io() && cpu_wr && ((m_off() == 16'h0 && cpu_dout != 8'h00) || m_off() == 16'h4);
    endfunction

    function automatic logic m_rdy();
        return ext_rdy && !m_halted && !(m_txw() && m_txq.size() == TXD);
    endfunction

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_txq.delete();
            m_rxq.delete();
            m_cnt    = 32'h0;
            m_snap   = 32'h0;
            m_halted = 1'b0;
            m_done   = 1'b0;
            m_din    = 8'h00;
        end else begin
            logic       acc;
            logic       txne;
            logic       rxfull;
            logic       halt_nxt;
            logic [7:0] v;
            acc      = m_rdy();
            txne     = m_txq.size() != 0;
            rxfull   = m_rxq.size() == RXD;
            halt_nxt = 1'b0;
            m_done   = m_halted && !txne;
            if (acc && !cpu_wr) begin
                v = 8'h00;
                if (!m_io()) begin
                    if (m_mem.exists(int'(cpu_a[16:0]))) v = m_mem[int'(cpu_a[16:0])];
                end else begin
                    case (m_off())
                        16'h0: if (m_rxq.size() != 0) v = m_rxq.pop_front();
                        16'h4: begin v = m_cnt[7:0]; m_snap = m_cnt; end
                        16'h5: v = m_snap[15:8];
                        16'h6: v = m_snap[23:16];
                        16'h7: v = m_snap[31:24];
                        default: v = 8'h00;
                    endcase
                end
                m_din = v;
            end
            if (acc && cpu_wr) begin
                if (!m_io()) m_mem[int'(cpu_a[16:0])] = cpu_dout;
                else if (m_off() == 16'h0 && cpu_dout != 8'h00) m_txq.push_back(cpu_dout);
                else if (m_off() == 16'h4) begin
                    m_txq.push_back(8'h00);
                    halt_nxt = 1'b1;
                end
            end
            if (txne && tx_ready) void'(m_txq.pop_front());
            if (rx_valid && !rxfull) m_rxq.push_back(rx_data);
            if (ext_rdy && !m_halted) m_cnt = m_cnt + 32'd1;
            if (halt_nxt) m_halted = 1'b1;
        end
    end

    always @(negedge clk_in) begin
        if (rst_in) begin
            check("cpu_rdy", 32'(cpu_rdy), 32'(m_rdy()));
            check("cpu_din", 32'(cpu_din), 32'(m_din));
            check("ram_we", 32'(ram_we), 32'(m_rdy() && !m_io() && cpu_wr));
            if (ram_we) begin
                check("ram_a", 32'(ram_a), 32'(cpu_a[16:0]));
                check("ram_wdata", 32'(ram_wdata), 32'(cpu_dout));
            end
            check("tx_valid", 32'(tx_valid), 32'(m_txq.size() != 0));
            if (m_txq.size() != 0) check("tx_data", 32'(tx_data), 32'(m_txq[0]));
            check("rx_ready", 32'(rx_ready), 32'(m_rxq.size() < RXD));
            check("halted", 32'(halted), 32'(m_halted));
            check("sim_done", 32'(sim_done), 32'(m_done));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
        cpu_a    = a;
        cpu_wr   = wr;
        cpu_dout = d;
    endtask

    // Write of 0x00 to an unmapped IO address: accepted but has no effect.
    task automatic idle();
        drive(32'h0003_000C, 1'b1, 8'h00);
    endtask

    task automatic read_word(input logic [31:0] tgt, output logic [31:0] w, output logic hit);
        hit = 1'b0;
        w   = 32'h0;
        for (int k = 0; k < 2000; k++) begin
            if (m_cnt == tgt) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        drive(32'h0003_0004, 1'b0, 8'h00);
        step();
        for (int b = 1; b < 4; b++) begin
            drive(32'h0003_0004 + 32'(b), 1'b0, 8'h00);
            @(negedge clk_in);
            w[8*(b-1) +: 8] = cpu_din;
            step();
        end
        idle();
        @(negedge clk_in);
        w[31:24] = cpu_din;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic        hit;
        for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
        rst_in   = 1'b0;
        ext_rdy  = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle();
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_cpu_din", 32'(cpu_din), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_sim_done", 32'(sim_done), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        step();
        rst_in = 1'b1;

        // RAM write then read back
        drive(32'h0000_0123, 1'b1, 8'hA5);
        @(negedge clk_in);
        check("ram_wr_we", 32'(ram_we), 32'h1);
        check("ram_wr_a", 32'(ram_a), 32'h123);
        step();
        drive(32'h0000_0123, 1'b0, 8'h00);
        step();
        idle();
        @(negedge clk_in);
        check("ram_rd_din", 32'(cpu_din), 32'hA5);

        // TX byte, then a zero byte that must be dropped
        step();
        drive(32'h0003_0000, 1'b1, 8'h41);
        step();
        drive(32'h0003_0000, 1'b1, 8'h00);
        @(negedge clk_in);
        check("tx_first_valid", 32'(tx_valid), 32'h1);
        check("tx_first_data", 32'(tx_data), 32'h41);
        step();
        idle();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        @(negedge clk_in);
        check("tx_zero_dropped", 32'(tx_valid), 32'h0);

        // TX full back-pressure
        step();
        for (int i = 0; i < 17; i++) begin
            drive(32'h0003_0000, 1'b1, 8'h42);
            @(negedge clk_in);
            check("tx_fill_rdy", 32'(cpu_rdy), (i < 16) ? 32'h1 : 32'h0);
            if (i < 16) step();
        end
        step();
        @(negedge clk_in);
        check("tx_full_hold", 32'(cpu_rdy), 32'h0);
        step();
        tx_ready = 1'b1;
        @(negedge clk_in);
        check("tx_full_pop_cycle", 32'(cpu_rdy), 32'h0);
        step();
        tx_ready = 1'b0;
        @(negedge clk_in);
        check("tx_full_release", 32'(cpu_rdy), 32'h1);
        step();
        idle();
        tx_ready = 1'b1;
        repeat (18) step();
        tx_ready = 1'b0;
        @(negedge clk_in);
        check("tx_drained", 32'(tx_valid), 32'h0);

        // Counter snapshot coherence
        step();
        read_word(32'h0000_00FE, w, hit);
        check("cnt_fe_reached", 32'(hit), 32'h1);
        check("cnt_fe_word", w, 32'h0000_00FE);
        step();
        read_word(32'h0000_01FF, w, hit);
        check("cnt_1ff_reached", 32'(hit), 32'h1);
        check("cnt_1ff_word", w, 32'h0000_01FF);

        // RX path
        step();
        drive(32'h0003_0000, 1'b0, 8'h00);
        step();
        idle();
        @(negedge clk_in);
        check("rx_empty_rd", 32'(cpu_din), 32'h00);
        step();
        drive(32'h0003_0000, 1'b0, 8'h00);
        rx_data  = 8'h37;
        rx_valid = 1'b1;
        step();
        idle();
        rx_valid = 1'b0;
        @(negedge clk_in);
        check("rx_push_same_rd", 32'(cpu_din), 32'h00);
        step();
        drive(32'h0003_0000, 1'b0, 8'h00);
        step();
        idle();
        @(negedge clk_in);
        check("rx_rd_37", 32'(cpu_din), 32'h37);
        step();
        for (int i = 0; i < 17; i++) begin
            rx_data  = 8'h60 + 8'(i);
            rx_valid = 1'b1;
            step();
        end
        rx_valid = 1'b0;
        @(negedge clk_in);
        check("rx_full_rdy", 32'(rx_ready), 32'h0);
        step();
        for (int i = 0; i < 16; i++) begin
            drive(32'h0003_0000, 1'b0, 8'h00);
            step();
        end
        idle();
        @(negedge clk_in);
        check("rx_last_byte", 32'(cpu_din), 32'h6F);

        // Halt with TX empty, then drain to sim_done
        step();
        drive(32'h0003_0004, 1'b1, 8'h99);
        step();
        idle();
        @(negedge clk_in);
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_cpu_rdy", 32'(cpu_rdy), 32'h0);
        check("halt_tx_valid", 32'(tx_valid), 32'h1);
        check("halt_tx_data", 32'(tx_data), 32'h00);
        step();
        tx_ready = 1'b1;
        step();
        step();
        tx_ready = 1'b0;
        @(negedge clk_in);
        check("halt_sim_done", 32'(sim_done), 32'h1);
        step();
        rst_in = 1'b0;
        step();
        rst_in = 1'b1;

        // Reset in the middle of a TX drain after halt
        drive(32'h0000_0123, 1'b0, 8'h00);
        step();
        drive(32'h0003_0000, 1'b1, 8'h51);
        step();
        drive(32'h0003_0000, 1'b1, 8'h52);
        step();
        drive(32'h0003_0004, 1'b1, 8'h00);
        step();
        idle();
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        @(negedge clk_in);
        check("drain_tx_valid", 32'(tx_valid), 32'h1);
        check("drain_tx_data", 32'(tx_data), 32'h52);
        check("drain_cpu_din", 32'(cpu_din), 32'hA5);
        check("drain_halted", 32'(halted), 32'h1);
        #2;
        drive(32'h0000_0200, 1'b1, 8'h77);
        rst_in = 1'b0;
        #1;
        check("mid_rst_cpu_din", 32'(cpu_din), 32'h0);
        check("mid_rst_halted", 32'(halted), 32'h0);
        check("mid_rst_sim_done", 32'(sim_done), 32'h0);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
        check("mid_rst_rx_ready", 32'(rx_ready), 32'h0);
        check("mid_rst_ram_we", 32'(ram_we), 32'h0);
        step();
        idle();
        step();
        rst_in = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
